// File: rtl/fpu_div.sv
// fpu_div: iterative IEEE754 single-precision divider (restoring radix-2) behind valid/ready.
// Define FPU_DIV_RNE_EN for round-to-nearest-even; the default build truncates.
module fpu_div #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } float_t;
    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
    state_t state, state_n;
    float_t a, b;
    logic sign, s_in, accept, special, nan, a_zero, b_zero, a_inf, b_inf, ge, guard, sticky;
    logic signed [9:0] exp, e_n;
    logic [23:0] mb;
    logic [24:0] rem, rem_n;
    logic [25:0] q, q_n;
    logic [4:0] cnt, cnt_n;
    logic [22:0] mant;
    logic [31:0] special_res, norm_res;
    assign a = operand_a;
    assign b = operand_b;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign accept = in_valid & in_ready;
    assign s_in = a.sign ^ b.sign;
    // exponent 0 flushes denormals to zero; exponent 255 is inf or NaN
    assign a_zero = a.exponent == 8'd0;
    assign b_zero = b.exponent == 8'd0;
    assign a_inf = &a.exponent & (a.fraction == 23'd0);
    assign b_inf = &b.exponent & (b.fraction == 23'd0);
    assign nan = (&a.exponent & !a_inf) | (&b.exponent & !b_inf) | (a_zero & b_zero) | (a_inf & b_inf);
    assign special = a_zero | b_zero | &a.exponent | &b.exponent;
    assign special_res = nan ? 32'h7FC00000 : (b_zero | a_inf) ? {s_in, 8'hFF, 23'd0} : {s_in, 31'd0};
    assign cnt_n = cnt + 5'(STEPS_PER_CYCLE);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   state_n = accept ? (special ? DONE : DIVIDE) : IDLE;
            DIVIDE: state_n = cnt_n == 5'd26 ? NORM : DIVIDE;
            NORM:   state_n = DONE;
            DONE:   state_n = out_ready ? IDLE : DONE;
        endcase
    end
    always_comb begin
        rem_n = rem;
        q_n = q;
        ge = 1'b0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            ge = rem_n >= {1'b0, mb};
            rem_n = (ge ? rem_n - {1'b0, mb} : rem_n) << 1;
            q_n = {q_n[24:0], ge};
        end
    end
`ifdef FPU_DIV_RNE_EN
    logic carry;
`else
    logic unused_round;
    assign unused_round = guard | sticky;
`endif
    // q[25] set means the mantissa ratio was >= 1, otherwise shift left one and borrow from exp
    always_comb begin
        mant = q[25] ? q[24:2] : q[23:1];
        guard = q[25] ? q[1] : q[0];
        sticky = (q[25] & q[0]) | (rem != 25'd0);
        e_n = q[25] ? exp : exp - 10'sd1;
`ifdef FPU_DIV_RNE_EN
        {carry, mant} = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
        e_n = carry ? e_n + 10'sd1 : e_n;
`endif
        norm_res = e_n >= 10'sd255 ? {sign, 8'hFF, 23'd0} :
                   e_n <= 10'sd0   ? {sign, 31'd0} : {sign, e_n[7:0], mant};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign <= 1'b0;
            exp <= '0;
            mb <= '0;
            rem <= '0;
            q <= '0;
            cnt <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                sign <= s_in;
                exp <= 10'({2'b0, a.exponent}) - 10'({2'b0, b.exponent}) + 10'sd127;
                mb <= {1'b1, b.fraction};
                rem <= {2'b01, a.fraction};
                q <= '0;
                cnt <= '0;
                if (special) result <= special_res;
            end
            if (state == DIVIDE) begin
                rem <= rem_n;
                q <= q_n;
                cnt <= cnt_n;
            end
            if (state == NORM) result <= norm_res;
        end
    end
endmodule
